// File: rtl/pkt_classifier_pkg.sv
// Shared header offsets, match constants and FSM/destination types for axis_pkt_classifier.
// Byte offsets assume a 512-bit first beat with byte n at tdata[8n+7:8n].
package pkt_classifier_pkg;

    localparam int unsigned TPID_OFF      = 12;
    localparam int unsigned ETYPE_OFF     = 16;
    localparam int unsigned IP_PROTO_OFF  = 27;
    localparam int unsigned UDP_DPORT_OFF = 40;

    localparam logic [15:0] TPID_VLAN  = 16'h8100;
    localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  PROTO_UDP  = 8'h11;

    typedef enum logic [1:0] {
        StIdle,
        StFwdData,
        StFwdCtrl,
        StDrop
    } state_e;

    typedef enum logic [1:0] {
        DestData,
        DestCtrl,
        DestDrop
    } dest_e;

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry AXI-Stream register slice; the parent only pulses in_valid when in_ready is high.
module axis_reg_slice #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned KEEP_W = 64,
    parameter int unsigned USER_W = 128
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic [USER_W-1:0] in_user,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic [USER_W-1:0] out_user,
    output logic              out_last
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [KEEP_W-1:0] keep_q;
    logic [USER_W-1:0] user_q;
    logic              last_q;

    assign in_ready = ~valid_q | out_ready;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            user_q  <= '0;
            last_q  <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
            keep_q  <= in_keep;
            user_q  <= in_user;
            last_q  <= in_last;
        end else if (out_ready) begin
            // Payload is left as-is; only valid drops once the beat is taken.
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_user  = user_q;
    assign out_last  = last_q;

endmodule

// File: rtl/axis_pkt_classifier.sv
// Steers each AXI-Stream packet to the data or control output based on its first beat.
// Optional macro CLASSIFIER_DROP_UNTAGGED_EN discards packets without an 802.1Q tag.
module axis_pkt_classifier
    import pkt_classifier_pkg::*;
#(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter logic [15:0] CTRL_UDP_PORT        = 16'hF1F2,
    parameter int unsigned CNT_WIDTH            = 32
) (
    input  logic                              clk,
    input  logic                              aresetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_axis_tuser,
    output logic                              c_axis_tvalid,
    output logic                              c_axis_tlast,
    input  logic                              c_axis_tready,

    output logic [CNT_WIDTH-1:0]              data_pkt_cnt,
    output logic [CNT_WIDTH-1:0]              ctrl_pkt_cnt,
    output logic [CNT_WIDTH-1:0]              drop_pkt_cnt
);

    localparam int unsigned KeepW = C_S_AXIS_DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    state_e                state_q;
    dest_e                 cls;
    dest_e                 sel;
    logic [CNT_WIDTH-1:0]  data_cnt_q;
    logic [CNT_WIDTH-1:0]  ctrl_cnt_q;
    logic [CNT_WIDTH-1:0]  drop_cnt_q;

    logic [15:0] tpid;
    logic [15:0] etype;
    logic [7:0]  proto;
    logic [15:0] dport;

    logic m_in_ready;
    logic c_in_ready;
    logic s_ready;
    logic s_hs;
    logic m_load;
    logic c_load;

    assign tpid  = {s_axis_tdata[8*TPID_OFF +: 8], s_axis_tdata[8*(TPID_OFF+1) +: 8]};
    assign etype = {s_axis_tdata[8*ETYPE_OFF +: 8], s_axis_tdata[8*(ETYPE_OFF+1) +: 8]};
    assign proto = s_axis_tdata[8*IP_PROTO_OFF +: 8];
    assign dport = {s_axis_tdata[8*UDP_DPORT_OFF +: 8], s_axis_tdata[8*(UDP_DPORT_OFF+1) +: 8]};

    // Classification only matters in StIdle, where the current beat is a first beat.
    always_comb begin
        cls = DestData;
        if (tpid == TPID_VLAN && etype == ETYPE_IPV4 && proto == PROTO_UDP &&
            dport == CTRL_UDP_PORT) begin
            cls = DestCtrl;
        end
`ifdef CLASSIFIER_DROP_UNTAGGED_EN
        if (tpid != TPID_VLAN) begin
            cls = DestDrop;
        end
`endif
    end

    always_comb begin
        sel = DestData;
        case (state_q)
            StIdle:    sel = cls;
            StFwdData: sel = DestData;
            StFwdCtrl: sel = DestCtrl;
            StDrop:    sel = DestDrop;
            default:   sel = DestData;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        case (sel)
            DestData: s_ready = m_in_ready;
            DestCtrl: s_ready = c_in_ready;
            default:  s_ready = 1'b1;
        endcase
    end

    // Gating with aresetn keeps tready low while reset is held, even though both slices are empty.
    assign s_axis_tready = s_ready & aresetn;
    assign s_hs          = s_axis_tvalid & s_axis_tready;
    assign m_load        = s_hs & (sel == DestData);
    assign c_load        = s_hs & (sel == DestCtrl);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= StIdle;
            data_cnt_q <= '0;
            ctrl_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else if (s_hs) begin
            if (state_q == StIdle) begin
                case (cls)
                    DestCtrl: begin
                        ctrl_cnt_q <= ctrl_cnt_q + CntOne;
                        if (!s_axis_tlast) state_q <= StFwdCtrl;
                    end
                    DestDrop: begin
                        drop_cnt_q <= drop_cnt_q + CntOne;
                        if (!s_axis_tlast) state_q <= StDrop;
                    end
                    default: begin
                        data_cnt_q <= data_cnt_q + CntOne;
                        if (!s_axis_tlast) state_q <= StFwdData;
                    end
                endcase
            end else if (s_axis_tlast) begin
                state_q <= StIdle;
            end
        end
    end

    assign data_pkt_cnt = data_cnt_q;
    assign ctrl_pkt_cnt = ctrl_cnt_q;
    assign drop_pkt_cnt = drop_cnt_q;

    axis_reg_slice #(
        .DATA_W (C_S_AXIS_DATA_WIDTH),
        .KEEP_W (KeepW),
        .USER_W (C_S_AXIS_TUSER_WIDTH)
    ) u_data_slice (
        .clk       (clk),
        .aresetn   (aresetn),
        .in_valid  (m_load),
        .in_ready  (m_in_ready),
        .in_data   (s_axis_tdata),
        .in_keep   (s_axis_tkeep),
        .in_user   (s_axis_tuser),
        .in_last   (s_axis_tlast),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  (m_axis_tdata),
        .out_keep  (m_axis_tkeep),
        .out_user  (m_axis_tuser),
        .out_last  (m_axis_tlast)
    );

    axis_reg_slice #(
        .DATA_W (C_S_AXIS_DATA_WIDTH),
        .KEEP_W (KeepW),
        .USER_W (C_S_AXIS_TUSER_WIDTH)
    ) u_ctrl_slice (
        .clk       (clk),
        .aresetn   (aresetn),
        .in_valid  (c_load),
        .in_ready  (c_in_ready),
        .in_data   (s_axis_tdata),
        .in_keep   (s_axis_tkeep),
        .in_user   (s_axis_tuser),
        .in_last   (s_axis_tlast),
        .out_valid (c_axis_tvalid),
        .out_ready (c_axis_tready),
        .out_data  (c_axis_tdata),
        .out_keep  (c_axis_tkeep),
        .out_user  (c_axis_tuser),
        .out_last  (c_axis_tlast)
    );

endmodule

// File: tb/tb_axis_pkt_classifier.sv
// Directed self-checking bench for axis_pkt_classifier; honours CLASSIFIER_DROP_UNTAGGED_EN.
module tb_axis_pkt_classifier;

    logic         clk = 1'b0;
    logic         aresetn;
    logic [511:0] s_axis_tdata;
    logic [63:0]  s_axis_tkeep;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;
    logic [511:0] c_axis_tdata;
    logic [63:0]  c_axis_tkeep;
    logic [127:0] c_axis_tuser;
    logic         c_axis_tvalid;
    logic         c_axis_tlast;
    logic         c_axis_tready;
    logic [31:0]  data_pkt_cnt;
    logic [31:0]  ctrl_pkt_cnt;
    logic [31:0]  drop_pkt_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    axis_pkt_classifier dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .c_axis_tdata  (c_axis_tdata),
        .c_axis_tkeep  (c_axis_tkeep),
        .c_axis_tuser  (c_axis_tuser),
        .c_axis_tvalid (c_axis_tvalid),
        .c_axis_tlast  (c_axis_tlast),
        .c_axis_tready (c_axis_tready),
        .data_pkt_cnt  (data_pkt_cnt),
        .ctrl_pkt_cnt  (ctrl_pkt_cnt),
        .drop_pkt_cnt  (drop_pkt_cnt)
    );

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] mk_beat(input logic [15:0] tpid, input logic [15:0] etype,
                                             input logic [7:0] proto, input logic [15:0] dport,
                                             input logic [31:0] seed);
        logic [511:0] b;
        b = {16{seed}};
        b[8*12 +: 8] = tpid[15:8];
        b[8*13 +: 8] = tpid[7:0];
        b[8*16 +: 8] = etype[15:8];
        b[8*17 +: 8] = etype[7:0];
        b[8*27 +: 8] = proto;
        b[8*40 +: 8] = dport[15:8];
        b[8*41 +: 8] = dport[7:0];
        return b;
    endfunction

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic send(input logic [511:0] d, input logic [63:0] k, input logic [127:0] u,
                        input logic l);
        int n;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        #1;
        while (!s_axis_tready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            check_eq("tready_timeout", {511'b0, s_axis_tready}, 512'd1);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] b1, b2, b3;

        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        c_axis_tready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_m_valid", m_axis_tvalid, 0);
        check_eq("rst_c_valid", c_axis_tvalid, 0);
        check_eq("rst_m_data", m_axis_tdata, 0);
        check_eq("rst_s_ready", s_axis_tready, 0);
        check_eq("rst_cnt_data", data_pkt_cnt, 0);
        check_eq("rst_cnt_ctrl", ctrl_pkt_cnt, 0);
        check_eq("rst_cnt_drop", drop_pkt_cnt, 0);
        aresetn = 1'b1;
        @(negedge clk);

        // Single-beat data packet
        b1 = mk_beat(16'h8100, 16'h0800, 8'h11, 16'h10E1, 32'h1111_0001);
        send(b1, '1, 128'hC0DE, 1'b1);
        check_eq("t1_m_valid", m_axis_tvalid, 1);
        check_eq("t1_m_data", m_axis_tdata, b1);
        check_eq("t1_m_user", m_axis_tuser, 128'hC0DE);
        check_eq("t1_m_keep", m_axis_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("t1_m_last", m_axis_tlast, 1);
        check_eq("t1_c_valid", c_axis_tvalid, 0);
        check_eq("t1_cnt_data", data_pkt_cnt, 1);
        idle();
        @(negedge clk);
        check_eq("t1_m_valid_clr", m_axis_tvalid, 0);

        // Two-beat control packet, back to back
        b1 = mk_beat(16'h8100, 16'h0800, 8'h11, 16'hF1F2, 32'h2222_0002);
        b2 = {16{32'hDEAD_0002}};
        send(b1, '1, 128'h21, 1'b0);
        check_eq("t2_c_valid1", c_axis_tvalid, 1);
        check_eq("t2_c_data1", c_axis_tdata, b1);
        check_eq("t2_c_last1", c_axis_tlast, 0);
        check_eq("t2_m_valid", m_axis_tvalid, 0);
        send(b2, 64'hFFFFF, 128'h22, 1'b1);
        check_eq("t2_c_data2", c_axis_tdata, b2);
        check_eq("t2_c_keep2", c_axis_tkeep, 64'hFFFFF);
        check_eq("t2_c_user2", c_axis_tuser, 128'h22);
        check_eq("t2_c_last2", c_axis_tlast, 1);
        check_eq("t2_cnt_ctrl", ctrl_pkt_cnt, 1);
        idle();
        @(negedge clk);

        // Control output stalled
        c_axis_tready = 1'b0;
        b1 = mk_beat(16'h8100, 16'h0800, 8'h11, 16'hF1F2, 32'h3333_0003);
        b2 = {16{32'hBEEF_0003}};
        send(b1, '1, 128'h31, 1'b0);
        check_eq("t3_c_data1", c_axis_tdata, b1);
        s_axis_tdata  = b2;
        s_axis_tkeep  = '1;
        s_axis_tuser  = 128'h32;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        #1;
        check_eq("t3_s_ready_stall", s_axis_tready, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t3_c_hold", c_axis_tdata, b1);
            check_eq("t3_c_valid_hold", c_axis_tvalid, 1);
            check_eq("t3_s_ready_hold", s_axis_tready, 0);
        end
        c_axis_tready = 1'b1;
        #1;
        check_eq("t3_s_ready_rel", s_axis_tready, 1);
        @(posedge clk);
        @(negedge clk);
        check_eq("t3_c_data2", c_axis_tdata, b2);
        check_eq("t3_c_last2", c_axis_tlast, 1);
        idle();
        @(negedge clk);
        check_eq("t3_c_no_dup", c_axis_tvalid, 0);
        check_eq("t3_cnt_ctrl", ctrl_pkt_cnt, 2);

        // Stalled data output does not block a control packet
        m_axis_tready = 1'b0;
        b1 = mk_beat(16'h8100, 16'h0800, 8'h11, 16'h0050, 32'h4444_0004);
        b2 = mk_beat(16'h8100, 16'h0800, 8'h11, 16'hF1F2, 32'h5555_0005);
        send(b1, '1, 128'h41, 1'b1);
        check_eq("t4_m_valid", m_axis_tvalid, 1);
        send(b2, '1, 128'h51, 1'b1);
        check_eq("t4_c_valid", c_axis_tvalid, 1);
        check_eq("t4_c_data", c_axis_tdata, b2);
        check_eq("t4_m_hold", m_axis_tdata, b1);
        idle();
        m_axis_tready = 1'b1;
        @(negedge clk);
        check_eq("t4_m_valid_clr", m_axis_tvalid, 0);
        check_eq("t4_cnt_data", data_pkt_cnt, 2);
        check_eq("t4_cnt_ctrl", ctrl_pkt_cnt, 3);

        // Untagged single-beat packet
        b1 = mk_beat(16'h0800, 16'h0800, 8'h11, 16'hF1F2, 32'h6666_0006);
        s_axis_tdata  = b1;
        s_axis_tkeep  = '1;
        s_axis_tuser  = 128'h61;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        #1;
        check_eq("t5_s_ready", s_axis_tready, 1);
        send(b1, '1, 128'h61, 1'b1);
        check_eq("t5_c_valid", c_axis_tvalid, 0);
`ifdef CLASSIFIER_DROP_UNTAGGED_EN
        check_eq("t5_m_valid", m_axis_tvalid, 0);
        check_eq("t5_cnt_drop", drop_pkt_cnt, 1);
        check_eq("t5_cnt_data", data_pkt_cnt, 2);
`else
        check_eq("t5_m_valid", m_axis_tvalid, 1);
        check_eq("t5_m_data", m_axis_tdata, b1);
        check_eq("t5_cnt_drop", drop_pkt_cnt, 0);
        check_eq("t5_cnt_data", data_pkt_cnt, 3);
`endif
        idle();
        @(negedge clk);

        // Reset during beat 2 of a 3-beat control packet
        b1 = mk_beat(16'h8100, 16'h0800, 8'h11, 16'hF1F2, 32'h7777_0007);
        b2 = {16{32'hCAFE_0007}};
        send(b1, '1, 128'h71, 1'b0);
        check_eq("t6_c_valid1", c_axis_tvalid, 1);
        s_axis_tdata  = b2;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        #2;
        aresetn = 1'b0;
        #1;
        check_eq("t6_c_valid_rst", c_axis_tvalid, 0);
        check_eq("t6_cnt_ctrl_rst", ctrl_pkt_cnt, 0);
        check_eq("t6_cnt_data_rst", data_pkt_cnt, 0);
        check_eq("t6_s_ready_rst", s_axis_tready, 0);
        idle();
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        b3 = mk_beat(16'h8100, 16'h0800, 8'h11, 16'h1234, 32'h8888_0008);
        send(b3, '1, 128'h81, 1'b1);
        check_eq("t6_m_valid", m_axis_tvalid, 1);
        check_eq("t6_m_data", m_axis_tdata, b3);
        check_eq("t6_c_valid", c_axis_tvalid, 0);
        check_eq("t6_cnt_data", data_pkt_cnt, 1);
        check_eq("t6_cnt_ctrl", ctrl_pkt_cnt, 0);
        idle();
        @(negedge clk);

        // Counter wrap
        force dut.data_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.data_cnt_q;
        b1 = mk_beat(16'h8100, 16'h0800, 8'h06, 16'hF1F2, 32'h9999_0009);
        send(b1, '1, 128'h91, 1'b1);
        check_eq("t7_m_data", m_axis_tdata, b1);
        check_eq("t7_cnt_wrap", data_pkt_cnt, 0);
        check_eq("t7_cnt_ctrl", ctrl_pkt_cnt, 0);
        idle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
